song_reader: RTL and testbench

//  Sequencer that drives the note player's load interface. Walks one song's

---
 rtl/song_reader.sv | 137 +++++++++++++
 tb/tb_song_reader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// Song sequencer: walks one song's {note, duration} list in an external
// synchronous ROM and feeds each entry to the note player's load interface.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | song select tracked; waits for play
// FETCH     | rom_addr = {song_q, idx} presented to the ROM
// WAIT_ROM  | rom_data valid; zero duration ends the song, else latch it
// LOAD      | new_note strobed while play is high
// WAIT_DONE | waits for a note_done rising edge, then advances the index
// END       | song finished; held until restart
module song_reader #(
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      play,
  input  logic                      restart,
  input  logic [SONG_W-1:0]         song,
  input  logic                      note_done,
  output logic [SONG_W+IDX_W-1:0]   rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic [NOTE_W-1:0]         note,
  output logic [DUR_W-1:0]          duration,
  output logic                      new_note,
  output logic                      song_done,
  output logic [IDX_W-1:0]          note_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ROM,
    S_LOAD,
    S_WAIT_DONE,
    S_END
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  state_t              state_q, state_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic [SONG_W-1:0]   song_q, song_n;
  logic [NOTE_W-1:0]   note_n;
  logic [DUR_W-1:0]    dur_n;
  logic                done_seen_q, done_seen_n;
  logic                done_q;
  logic                done_rise;
  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;

  assign rom_note  = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur   = rom_data[DUR_W-1:0];
  assign done_rise = note_done & ~done_q;
  assign note_idx  = idx_q;

  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    song_n      = song_q;
    note_n      = note;
    dur_n       = duration;
    done_seen_n = done_seen_q;
    new_note    = 1'b0;

    case (state_q)
      S_IDLE: begin
        song_n = song;
        if (play) state_n = S_FETCH;
      end
      S_FETCH: state_n = S_WAIT_ROM;
      S_WAIT_ROM: begin
        if (rom_dur == '0) begin
          state_n = S_END;
        end else begin
          note_n  = rom_note;
          dur_n   = rom_dur;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        new_note = play;
        if (play) state_n = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done_rise) done_seen_n = 1'b1;
        // Last slot ends the song rather than wrapping into the next one.
        if (done_seen_q && play) begin
          done_seen_n = 1'b0;
          if (idx_q == IDX_LAST) begin
            state_n = S_END;
          end else begin
            idx_n   = idx_q + IDX_W'(1);
            state_n = S_FETCH;
          end
        end
      end
      S_END: state_n = S_END;
      default: state_n = S_IDLE;
    endcase

    if (restart) begin
      state_n     = S_IDLE;
      idx_n       = '0;
      done_seen_n = 1'b0;
      song_n      = song;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      song_q      <= '0;
      rom_addr    <= '0;
      note        <= '0;
      duration    <= '0;
      song_done   <= 1'b0;
      done_seen_q <= 1'b0;
      done_q      <= 1'b1;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      song_q      <= song_n;
      rom_addr    <= {song_n, idx_n};
      note        <= note_n;
      duration    <= dur_n;
      song_done   <= (state_n == S_END) && (state_q != S_END);
      done_seen_q <= done_seen_n;
      done_q      <= note_done;
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: a ROM model plus a scoreboard that pops the
// expected load / song-end event whenever the DUT strobes one.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        play;
  logic        restart;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;
  logic [4:0]  note_idx;

  song_reader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .play      (play),
    .restart   (restart),
    .song      (song),
    .note_done (note_done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note      (note),
    .duration  (duration),
    .new_note  (new_note),
    .song_done (song_done),
    .note_idx  (note_idx)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [128];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    bit         is_end;
    logic [5:0] note;
    logic [5:0] dur;
    logic [4:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   load_cnt    = 0;
  bit   wrap_seen   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_load(input int n, input int d, input int i);
    exp_t e;
    e.is_end = 1'b0;
    e.note   = 6'(n);
    e.dur    = 6'(d);
    e.idx    = 5'(i);
    exp_q.push_back(e);
  endtask

  task automatic push_end(input int i);
    exp_t e;
    e.is_end = 1'b1;
    e.note   = '0;
    e.dur    = '0;
    e.idx    = 5'(i);
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic done_pulse();
    note_done = 1'b0;
    tick(2);
    note_done = 1'b1;
    tick(8);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (new_note) begin
        load_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL load: unexpected new_note note=%0d dur=%0d idx=%0d", note, duration, note_idx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.is_end || note !== e.note || duration !== e.dur || note_idx !== e.idx) begin
            miscompares++;
            $display("FAIL load: got end=0 note=%0d dur=%0d idx=%0d, expected end=%0d note=%0d dur=%0d idx=%0d",
                     note, duration, note_idx, e.is_end, e.note, e.dur, e.idx);
          end
        end
      end
      if (song_done) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL song_done: unexpected pulse at idx=%0d", note_idx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (!e.is_end || note_idx !== e.idx) begin
            miscompares++;
            $display("FAIL song_done: got end=1 idx=%0d, expected end=%0d idx=%0d", note_idx, e.is_end, e.idx);
          end
        end
      end
      if (rom_addr == 7'h60) wrap_seen = 1'b1;
    end
  end

  initial begin
    int base_cnt;
    for (int i = 0; i < 128; i++) rom[i] = {6'd1, 6'd1};
    rom[7'h20] = {6'd20, 6'd12};
    rom[7'h21] = {6'd21, 6'd5};
    rom[7'h22] = {6'd22, 6'd7};
    rom[7'h23] = {6'd33, 6'd0};
    for (int i = 0; i < 32; i++) rom[64 + i] = {6'(i + 1), 6'((i % 5) + 1)};
    rom[7'h00] = {6'd10, 6'd3};
    rom[7'h01] = {6'd11, 6'd4};
    rom[7'h02] = {6'd12, 6'd9};

    reset_n = 1'b0; play = 1'b0; restart = 1'b0; song = 2'd1; note_done = 1'b1;
    #3;
    check("rst_rom_addr", rom_addr, 0);
    check("rst_note", note, 0);
    check("rst_duration", duration, 0);
    check("rst_new_note", new_note, 0);
    check("rst_song_done", song_done, 0);
    check("rst_note_idx", note_idx, 0);
    tick(2);
    reset_n = 1'b1;
    tick();

    // first note: latency and address
    play = 1'b1;
    push_load(20, 12, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      @(negedge clk);
      check("lat_new_note", new_note, (i == 3) ? 1 : 0);
      if (i == 1) check("fetch_addr", rom_addr, 7'h20);
    end
    check("load_note", note, 20);
    check("load_dur", duration, 12);

    // stale done level high, then low, then a real edge
    tick(3);
    note_done = 1'b0;
    tick(10);
    check("no_adv_addr", rom_addr, 7'h20);
    check("no_adv_idx", note_idx, 0);
    push_load(21, 5, 1);
    note_done = 1'b1;
    tick(2);
    @(negedge clk);
    check("adv_addr", rom_addr, 7'h21);
    check("adv_idx", note_idx, 1);
    tick(6);
    check("one_adv_idx", note_idx, 1);

    // end marker at slot 3
    push_load(22, 7, 2);
    done_pulse();
    push_end(3);
    done_pulse();
    @(negedge clk);
    check("end_addr", rom_addr, 7'h23);
    check("end_note_hold", note, 22);
    check("end_dur_hold", duration, 7);
    tick(5);
    check("end_addr_stay", rom_addr, 7'h23);
    check("end_pulse_once", song_done, 0);

    // full 32-slot song
    for (int i = 0; i < 32; i++) push_load(i + 1, (i % 5) + 1, i);
    push_end(31);
    base_cnt = load_cnt;
    song = 2'd2; restart = 1'b1;
    tick();
    restart = 1'b0;
    tick(4);
    repeat (32) done_pulse();
    @(negedge clk);
    check("full_loads", load_cnt - base_cnt, 32);
    check("full_no_wrap", wrap_seen, 0);
    check("full_idx", note_idx, 31);
    check("full_addr", rom_addr, 7'h5F);

    // play low in WAIT_DONE gates the advance
    song = 2'd0;
    push_load(10, 3, 0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick(4);
    play = 1'b0;
    note_done = 1'b0;
    tick(2);
    note_done = 1'b1;
    tick(6);
    check("paused_idx", note_idx, 0);
    check("paused_addr", rom_addr, 7'h00);
    push_load(11, 4, 1);
    play = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      @(negedge clk);
      check("resume_new_note", new_note, (i == 3) ? 1 : 0);
      if (i == 1) check("resume_addr", rom_addr, 7'h01);
    end

    // play low through WAIT_ROM into LOAD holds the strobe off
    push_load(12, 9, 2);
    note_done = 1'b0;
    tick(2);
    note_done = 1'b1;
    tick(3);
    play = 1'b0;
    tick();
    @(negedge clk);
    check("hold_new_note", new_note, 0);
    check("hold_note", note, 12);
    check("hold_dur", duration, 9);
    tick(2);
    @(negedge clk);
    check("hold_new_note2", new_note, 0);
    tick();
    play = 1'b1;
    @(negedge clk);
    check("release_new_note", new_note, 1);
    tick();
    @(negedge clk);
    check("after_strobe", new_note, 0);

    // restart beats a simultaneous done edge
    note_done = 1'b0;
    tick(2);
    note_done = 1'b1; restart = 1'b1; play = 1'b0; song = 2'd2;
    tick();
    restart = 1'b0;
    @(negedge clk);
    check("rs_idx", note_idx, 0);
    check("rs_note_hold", note, 12);
    check("rs_dur_hold", duration, 9);
    tick(4);
    check("rs_addr", rom_addr, 7'h40);
    check("rs_idx_stay", note_idx, 0);

    // async reset in WAIT_ROM
    play = 1'b1;
    tick(2);
    reset_n = 1'b0;
    #2;
    check("arst_rom_addr", rom_addr, 0);
    check("arst_note", note, 0);
    check("arst_duration", duration, 0);
    check("arst_new_note", new_note, 0);
    check("arst_song_done", song_done, 0);
    play = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
